// File: rtl/uiip_pkg.sv
// Shared definitions for the UIIP MAC transmit path: EtherType constants and
// the transmit arbiter state encoding.
package uiip_pkg;

    localparam logic [15:0] ARP_TYPE = 16'h0806;
    localparam logic [15:0] IP_TYPE  = 16'h0800;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_e;

endpackage : uiip_pkg

// File: rtl/uiip_rr_arb2.sv
// Two-way round-robin picker between the ARP and IP transmit requesters.
// The pointer only moves when the owner commits a grant via advance.
module uiip_rr_arb2 (
    input  logic I_ip_arp_rclk,
    input  logic I_ip_arp_reset,
    input  logic arp_req,
    input  logic ip_req,
    input  logic advance,
    output logic pick_arp,
    output logic pick_ip
);

    logic last_arp_r;

    // Pick a winner: a lone requester always wins, a tie goes to the one not served last.
    always_comb begin
        pick_arp = 1'b0;
        pick_ip  = 1'b0;
        if (arp_req && ip_req) begin
            if (last_arp_r) begin
                pick_ip = 1'b1;
            end else begin
                pick_arp = 1'b1;
            end
        end else if (arp_req) begin
            pick_arp = 1'b1;
        end else if (ip_req) begin
            pick_ip = 1'b1;
        end else begin
            pick_arp = 1'b0;
            pick_ip  = 1'b0;
        end
    end

    // Remember who was served last; reset leaves ARP first in line.
    always_ff @(posedge I_ip_arp_rclk or posedge I_ip_arp_reset) begin
        if (I_ip_arp_reset) begin
            last_arp_r <= 1'b0;
        end else if (advance) begin
            last_arp_r <= pick_arp;
        end else begin
            last_arp_r <= last_arp_r;
        end
    end

endmodule : uiip_rr_arb2

// File: rtl/uiip_arp_tx_arb.sv
// Arbitrates the MAC transmit path between the ARP and IP frame sources,
// forwarding the granted byte stream with one cycle of latency and enforcing an inter-frame gap.
module uiip_arp_tx_arb
    import uiip_pkg::*;
#(
    parameter int IFG_CYCLES    = 12,
    parameter int GRANT_TIMEOUT = 64
) (
    input  logic        I_ip_arp_rclk,
    input  logic        I_ip_arp_reset,
    input  logic        I_arp_treq,
    output logic        O_arp_tgrant,
    input  logic        I_arp_tvalid,
    input  logic [7:0]  I_arp_tdata,
    input  logic        I_ip_treq,
    output logic        O_ip_tgrant,
    input  logic        I_ip_tvalid,
    input  logic [7:0]  I_ip_tdata,
    input  logic        I_mac_tbusy,
    output logic        O_mac_tvalid,
    output logic [7:0]  O_mac_tdata,
    output logic [15:0] O_mac_tdata_type,
    output logic        O_drop
);

    localparam int GAP_W = $clog2(IFG_CYCLES) + 1;
    localparam int TO_W  = $clog2(GRANT_TIMEOUT) + 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IFG_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(GRANT_TIMEOUT - 1);

    arb_state_e  state_r, state_s;
    logic        arp_grant_r, arp_grant_s;
    logic        ip_grant_r, ip_grant_s;
    logic        mac_tvalid_r, mac_tvalid_s;
    logic [7:0]  mac_tdata_r, mac_tdata_s;
    logic [15:0] type_r, type_s;
    logic        drop_r, drop_s;
    logic [GAP_W-1:0] gap_cnt_r, gap_cnt_s;
    logic [TO_W-1:0]  to_cnt_r, to_cnt_s;
    logic        seen_r, seen_s;
    logic        advance_s;
    logic        pick_arp_s, pick_ip_s;
    logic        gvalid_s, ovalid_s;
    logic [7:0]  gdata_s;

    uiip_rr_arb2 u_rr (
        .I_ip_arp_rclk  (I_ip_arp_rclk),
        .I_ip_arp_reset (I_ip_arp_reset),
        .arp_req        (I_arp_treq),
        .ip_req         (I_ip_treq),
        .advance        (advance_s),
        .pick_arp       (pick_arp_s),
        .pick_ip        (pick_ip_s)
    );

    // Split the inputs into the granted stream and the intruding one.
    always_comb begin
        if (arp_grant_r) begin
            gvalid_s = I_arp_tvalid;
            gdata_s  = I_arp_tdata;
            ovalid_s = I_ip_tvalid;
        end else begin
            gvalid_s = I_ip_tvalid;
            gdata_s  = I_ip_tdata;
            ovalid_s = I_arp_tvalid;
        end
    end

    // Next-state and next-output logic of the arbiter.
    always_comb begin
        state_s      = state_r;
        arp_grant_s  = arp_grant_r;
        ip_grant_s   = ip_grant_r;
        type_s       = type_r;
        gap_cnt_s    = gap_cnt_r;
        to_cnt_s     = to_cnt_r;
        seen_s       = seen_r;
        mac_tvalid_s = 1'b0;
        mac_tdata_s  = 8'h00;
        drop_s       = 1'b0;
        advance_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                gap_cnt_s = {GAP_W{1'b0}};
                to_cnt_s  = {TO_W{1'b0}};
                seen_s    = 1'b0;
                if (!I_mac_tbusy && (I_arp_treq || I_ip_treq)) begin
                    advance_s   = 1'b1;
                    state_s     = ST_XFER;
                    arp_grant_s = pick_arp_s;
                    ip_grant_s  = pick_ip_s;
                    type_s      = pick_arp_s ? ARP_TYPE : IP_TYPE;
                end else begin
                    arp_grant_s = 1'b0;
                    ip_grant_s  = 1'b0;
                end
            end
            ST_XFER: begin
                mac_tvalid_s = gvalid_s;
                mac_tdata_s  = gvalid_s ? gdata_s : 8'h00;
                // Intruding bytes are never forwarded, only flagged.
                drop_s       = ovalid_s;
                if (gvalid_s) begin
                    seen_s = 1'b1;
                end else if (seen_r) begin
                    state_s     = ST_GAP;
                    arp_grant_s = 1'b0;
                    ip_grant_s  = 1'b0;
                end else if (to_cnt_r >= TO_LAST) begin
                    drop_s      = 1'b1;
                    state_s     = ST_GAP;
                    arp_grant_s = 1'b0;
                    ip_grant_s  = 1'b0;
                end else begin
                    to_cnt_s = to_cnt_r + TO_W'(1);
                end
            end
            ST_GAP: begin
                arp_grant_s = 1'b0;
                ip_grant_s  = 1'b0;
                if (gap_cnt_r >= GAP_LAST) begin
                    state_s   = ST_IDLE;
                    gap_cnt_s = {GAP_W{1'b0}};
                end else begin
                    gap_cnt_s = gap_cnt_r + GAP_W'(1);
                end
            end
            default: begin
                state_s     = ST_IDLE;
                arp_grant_s = 1'b0;
                ip_grant_s  = 1'b0;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge I_ip_arp_rclk or posedge I_ip_arp_reset) begin
        if (I_ip_arp_reset) begin
            state_r      <= ST_IDLE;
            arp_grant_r  <= 1'b0;
            ip_grant_r   <= 1'b0;
            mac_tvalid_r <= 1'b0;
            mac_tdata_r  <= 8'h00;
            type_r       <= 16'h0000;
            drop_r       <= 1'b0;
            gap_cnt_r    <= {GAP_W{1'b0}};
            to_cnt_r     <= {TO_W{1'b0}};
            seen_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            arp_grant_r  <= arp_grant_s;
            ip_grant_r   <= ip_grant_s;
            mac_tvalid_r <= mac_tvalid_s;
            mac_tdata_r  <= mac_tdata_s;
            type_r       <= type_s;
            drop_r       <= drop_s;
            gap_cnt_r    <= gap_cnt_s;
            to_cnt_r     <= to_cnt_s;
            seen_r       <= seen_s;
        end
    end

    assign O_arp_tgrant     = arp_grant_r;
    assign O_ip_tgrant      = ip_grant_r;
    assign O_mac_tvalid     = mac_tvalid_r;
    assign O_mac_tdata      = mac_tdata_r;
    assign O_mac_tdata_type = type_r;
    assign O_drop           = drop_r;

endmodule : uiip_arp_tx_arb

// File: tb/tb_uiip_arp_tx_arb.sv
// Scoreboard bench for uiip_arp_tx_arb: driven bytes are queued with their
// EtherType and popped as the MAC side presents them.
module tb_uiip_arp_tx_arb;

    logic        clk;
    logic        rst;
    logic        arp_treq, arp_tvalid, ip_treq, ip_tvalid, mac_tbusy;
    logic [7:0]  arp_tdata, ip_tdata;
    logic        arp_tgrant, ip_tgrant, mac_tvalid, drop;
    logic [7:0]  mac_tdata;
    logic [15:0] mac_type;

    logic [23:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int drop_cnt = 0;

    uiip_arp_tx_arb #(.IFG_CYCLES(12), .GRANT_TIMEOUT(64)) dut (
        .I_ip_arp_rclk    (clk),
        .I_ip_arp_reset   (rst),
        .I_arp_treq       (arp_treq),
        .O_arp_tgrant     (arp_tgrant),
        .I_arp_tvalid     (arp_tvalid),
        .I_arp_tdata      (arp_tdata),
        .I_ip_treq        (ip_treq),
        .O_ip_tgrant      (ip_tgrant),
        .I_ip_tvalid      (ip_tvalid),
        .I_ip_tdata       (ip_tdata),
        .I_mac_tbusy      (mac_tbusy),
        .O_mac_tvalid     (mac_tvalid),
        .O_mac_tdata      (mac_tdata),
        .O_mac_tdata_type (mac_type),
        .O_drop           (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // MAC-side monitor: scoreboard pop, grant exclusivity, drop pulse count.
    always @(negedge clk) begin
        if (!rst) begin
            if (mac_tvalid) begin
                if (exp_q.size() == 0) begin
                    chk("mac_unexpected_byte", 32'(1), 32'(0));
                end else begin
                    chk("mac_byte", 32'({mac_type, mac_tdata}), 32'(exp_q.pop_front()));
                end
            end
            if (arp_tgrant && ip_tgrant) chk("grant_overlap", 32'(1), 32'(0));
            if (drop) drop_cnt++;
        end
    end

    // sel: 0 = IP grant, 1 = ARP grant, 2 = either grant.
    task automatic wait_grant(input int sel, output int n);
        bit got;
        got = 1'b0;
        n = 0;
        for (int i = 1; i <= 500 && !got; i++) begin
            @(posedge clk); #1;
            if ((sel == 1 && arp_tgrant) || (sel == 0 && ip_tgrant) ||
                (sel == 2 && (arp_tgrant || ip_tgrant))) begin
                got = 1'b1;
                n = i;
            end
        end
        if (!got) chk("grant_wait_timeout", 32'(0), 32'(1));
    endtask

    task automatic send_bytes(input bit arp, input int n, input int intrude);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d = 8'($urandom);
            if (arp) begin
                arp_tvalid = 1'b1;
                arp_tdata  = d;
                exp_q.push_back({16'h0806, d});
                ip_tvalid  = (i == intrude);
                ip_tdata   = 8'hEE;
            end else begin
                ip_tvalid  = 1'b1;
                ip_tdata   = d;
                exp_q.push_back({16'h0800, d});
                arp_tvalid = (i == intrude);
                arp_tdata  = 8'hEE;
            end
            @(posedge clk); #1;
        end
        arp_tvalid = 1'b0;
        ip_tvalid  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_arp_grant"}, 32'(arp_tgrant), 32'(0));
        chk({tag, "_ip_grant"},  32'(ip_tgrant),  32'(0));
        chk({tag, "_tvalid"},    32'(mac_tvalid), 32'(0));
        chk({tag, "_tdata"},     32'(mac_tdata),  32'(0));
        chk({tag, "_type"},      32'(mac_type),   32'(0));
        chk({tag, "_drop"},      32'(drop),       32'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cnt, d0;
        bit got;
        rst = 1'b1;
        arp_treq = 1'b0; arp_tvalid = 1'b0; arp_tdata = 8'h00;
        ip_treq = 1'b0; ip_tvalid = 1'b0; ip_tdata = 8'h00;
        mac_tbusy = 1'b0;
        idle(3);
        chk_outputs_zero("reset");
        rst = 1'b0;

        // ARP-only frame, then measure the gap before a waiting IP request
        arp_treq = 1'b1;
        wait_grant(1, n);
        chk("t1_arp_grant", 32'(arp_tgrant), 32'(1));
        chk("t1_ip_grant_low", 32'(ip_tgrant), 32'(0));
        chk("t1_type_arp", 32'(mac_type), 32'h0806);
        arp_treq = 1'b0;
        d0 = drop_cnt;
        send_bytes(1'b1, 28, -1);
        ip_treq = 1'b1;
        cnt = 0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk); #1;
            if (ip_tgrant) got = 1'b1;
            else cnt++;
        end
        chk("t1_gap_cycles", 32'(cnt), 32'(13));
        chk("t1_type_ip", 32'(mac_type), 32'h0800);
        ip_treq = 1'b0;
        send_bytes(1'b0, 20, -1);
        idle(3);
        chk("t1_q_empty", 32'(exp_q.size()), 32'(0));
        chk("t1_no_drop", 32'(drop_cnt - d0), 32'(0));

        // Tie from reset goes to ARP, then round-robin alternates
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        arp_treq = 1'b1;
        ip_treq  = 1'b1;
        wait_grant(2, n);
        chk("t2_tie_arp_grant", 32'(arp_tgrant), 32'(1));
        chk("t2_tie_ip_low", 32'(ip_tgrant), 32'(0));
        arp_treq = 1'b0;
        send_bytes(1'b1, 10, -1);
        wait_grant(0, n);
        chk("t2_type_ip", 32'(mac_type), 32'h0800);
        ip_treq = 1'b0;
        send_bytes(1'b0, 12, -1);
        arp_treq = 1'b1;
        ip_treq  = 1'b1;
        wait_grant(2, n);
        chk("t2_tie2_arp_grant", 32'(arp_tgrant), 32'(1));
        arp_treq = 1'b0;
        send_bytes(1'b1, 6, -1);
        wait_grant(2, n);
        chk("t2_then_ip_grant", 32'(ip_tgrant), 32'(1));
        ip_treq = 1'b0;
        send_bytes(1'b0, 6, -1);
        idle(3);
        chk("t2_q_empty", 32'(exp_q.size()), 32'(0));

        // MAC busy blocks grants; busy during a frame is ignored
        idle(20);
        mac_tbusy = 1'b1;
        ip_treq = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (arp_tgrant || ip_tgrant) cnt++;
        end
        chk("t3_no_grant_busy", 32'(cnt), 32'(0));
        mac_tbusy = 1'b0;
        wait_grant(0, n);
        chk("t3_release_latency", 32'(n), 32'(1));
        ip_treq = 1'b0;
        mac_tbusy = 1'b1;
        send_bytes(1'b0, 8, -1);
        mac_tbusy = 1'b0;
        idle(3);
        chk("t3_q_empty", 32'(exp_q.size()), 32'(0));

        // Grant timeout with no valid bytes
        idle(20);
        arp_treq = 1'b1;
        wait_grant(1, n);
        arp_treq = 1'b0;
        d0 = drop_cnt;
        cnt = 1;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk); #1;
            if (arp_tgrant) cnt++;
            else got = 1'b1;
        end
        chk("t4_grant_cycles", 32'(cnt), 32'(64));
        idle(2);
        chk("t4_drop_pulse", 32'(drop_cnt - d0), 32'(1));
        ip_treq = 1'b1;
        wait_grant(0, n);
        chk("t4_next_ip_grant", 32'(ip_tgrant), 32'(1));
        ip_treq = 1'b0;
        send_bytes(1'b0, 5, -1);
        idle(3);
        chk("t4_q_empty", 32'(exp_q.size()), 32'(0));

        // IP bytes intruding into an ARP frame
        idle(20);
        arp_treq = 1'b1;
        wait_grant(1, n);
        arp_treq = 1'b0;
        d0 = drop_cnt;
        send_bytes(1'b1, 16, 5);
        idle(3);
        chk("t5_intrude_drop", 32'(drop_cnt - d0), 32'(1));
        chk("t5_q_empty", 32'(exp_q.size()), 32'(0));

        // Reset in the middle of an IP frame
        idle(20);
        ip_treq = 1'b1;
        wait_grant(0, n);
        ip_treq = 1'b0;
        send_bytes(1'b0, 10, -1);
        ip_tvalid = 1'b1;
        rst = 1'b1;
        #1;
        chk_outputs_zero("t6_reset");
        exp_q.delete();
        arp_treq = 1'b1;
        ip_treq  = 1'b1;
        idle(3);
        ip_tvalid = 1'b0;
        rst = 1'b0;
        wait_grant(2, n);
        chk("t6_arp_first", 32'(arp_tgrant), 32'(1));
        chk("t6_grant_latency", 32'(n), 32'(1));
        arp_treq = 1'b0;
        send_bytes(1'b1, 8, -1);
        wait_grant(0, n);
        ip_treq = 1'b0;
        send_bytes(1'b0, 4, -1);
        idle(20);
        chk("final_q_empty", 32'(exp_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_uiip_arp_tx_arb
